// File: rtl/commit_ctrl.sv
// In-order commit sequencer: retires the ROB head into the RegFile, hands stores to the LSB,
// and flushes speculative state on a branch mispredict. Optional COMMIT_CNT_EN adds commit_count.
module commit_ctrl #(
  parameter int ROB_WIDTH_BIT = 4,
  parameter int FLUSH_CYCLES  = 1
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     head_valid,
  input  logic                     head_ready,
  input  logic [1:0]               head_type,
  input  logic [4:0]               head_rd,
  input  logic [ROB_WIDTH_BIT-1:0] head_rob_id,
  input  logic [31:0]              head_val,
  input  logic                     head_mispredict,
  input  logic [31:0]              head_target,
  output logic                     head_pop,
  output logic [4:0]               write_reg_id,
  output logic [ROB_WIDTH_BIT-1:0] write_ROB_id,
  output logic [31:0]              write_val,
  output logic                     store_commit_req,
  input  logic                     store_commit_ack,
  output logic                     redirect_valid,
  output logic [31:0]              redirect_pc,
  output logic                     clear_flag,
  output logic                     halted,
`ifdef COMMIT_CNT_EN
  output logic [31:0]              commit_count,
`endif
  output logic [1:0]               dbg_state
);

  // Handshake: the ROB dequeues its head in any cycle where head_pop is high (combinational,
  // qualified by rdy_in). store_commit_req stays high until the LSB returns store_commit_ack
  // for one cycle; an ack seen outside WAIT_STORE is ignored.

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_WAIT_STORE = 2'd1,
    ST_FLUSH      = 2'd2,
    ST_HALTED     = 2'd3
  } state_t;

  localparam logic [1:0] T_REG    = 2'd0;
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;
  localparam logic [1:0] T_HALT   = 2'd3;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t                   state, state_next;
  logic [2:0]               flush_cnt, flush_cnt_next;
  logic [4:0]               wreg_next;
  logic [ROB_WIDTH_BIT-1:0] wrob_next;
  logic [31:0]              wval_next;
  logic                     req_next;
  logic                     redir_next;
  logic [31:0]              rpc_next;
  logic                     clear_next;
  logic                     halted_next;
  logic                     pop_raw;
  logic                     accept;

  assign accept    = head_valid && head_ready;
  assign head_pop  = pop_raw && rdy_in && !rst_in;
  assign dbg_state = state;

  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    wreg_next      = 5'd0;
    wrob_next      = write_ROB_id;
    wval_next      = write_val;
    req_next       = store_commit_req;
    redir_next     = 1'b0;
    rpc_next       = redirect_pc;
    clear_next     = clear_flag;
    halted_next    = halted;
    pop_raw        = 1'b0;
    case (state)
      ST_RUN: begin
        if (accept) begin
          case (head_type)
            T_REG, T_BRANCH: begin
              pop_raw   = 1'b1;
              wreg_next = head_rd;
              wrob_next = head_rob_id;
              wval_next = head_val;
              // The link write still lands: the branch itself is architecturally committed.
              if (head_type == T_BRANCH && head_mispredict) begin
                redir_next     = 1'b1;
                rpc_next       = head_target;
                clear_next     = 1'b1;
                flush_cnt_next = FLUSH_LOAD;
                state_next     = ST_FLUSH;
              end
            end
            T_STORE: begin
              req_next   = 1'b1;
              state_next = ST_WAIT_STORE;
            end
            default: begin
              pop_raw     = 1'b1;
              halted_next = 1'b1;
              state_next  = ST_HALTED;
            end
          endcase
        end
      end
      ST_WAIT_STORE: begin
        if (store_commit_ack) begin
          pop_raw    = 1'b1;
          req_next   = 1'b0;
          state_next = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt != 3'd0) begin
          flush_cnt_next = flush_cnt - 3'd1;
        end else begin
          clear_next = 1'b0;
          state_next = ST_RUN;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state            <= ST_RUN;
      flush_cnt        <= 3'd0;
      write_reg_id     <= 5'd0;
      write_ROB_id     <= '0;
      write_val        <= 32'd0;
      store_commit_req <= 1'b0;
      redirect_valid   <= 1'b0;
      redirect_pc      <= 32'd0;
      clear_flag       <= 1'b0;
      halted           <= 1'b0;
    end else if (rdy_in) begin
      state            <= state_next;
      flush_cnt        <= flush_cnt_next;
      write_reg_id     <= wreg_next;
      write_ROB_id     <= wrob_next;
      write_val        <= wval_next;
      store_commit_req <= req_next;
      redirect_valid   <= redir_next;
      redirect_pc      <= rpc_next;
      clear_flag       <= clear_next;
      halted           <= halted_next;
    end
  end

`ifdef COMMIT_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      commit_count <= 32'd0;
    end else if (head_pop) begin
      commit_count <= commit_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_commit_ctrl.sv
// Bench for commit_ctrl: vector table, hand-written corner sequences, then random traffic
// checked against a flag-based reference model of the retirement rules.
module tb_commit_ctrl;
  localparam int RW = 4;
  localparam int FC = 2;
  localparam logic [1:0] T_REG = 2'd0, T_STORE = 2'd1, T_BRANCH = 2'd2, T_HALT = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rdy, hv, hr, hmis, ack;
  logic [1:0]    ht;
  logic [4:0]    hrd;
  logic [RW-1:0] hrob;
  logic [31:0]   hval, htgt;

  logic          head_pop, store_commit_req, redirect_valid, clear_flag, halted;
  logic [4:0]    write_reg_id;
  logic [RW-1:0] write_ROB_id;
  logic [31:0]   write_val, redirect_pc;
  logic [1:0]    dbg_state;
`ifdef COMMIT_CNT_EN
  logic [31:0]   commit_count;
`endif

  commit_ctrl #(.ROB_WIDTH_BIT(RW), .FLUSH_CYCLES(FC)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .head_valid(hv), .head_ready(hr), .head_type(ht), .head_rd(hrd),
    .head_rob_id(hrob), .head_val(hval), .head_mispredict(hmis), .head_target(htgt),
    .head_pop(head_pop), .write_reg_id(write_reg_id), .write_ROB_id(write_ROB_id),
    .write_val(write_val), .store_commit_req(store_commit_req), .store_commit_ack(ack),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .clear_flag(clear_flag),
    .halted(halted),
`ifdef COMMIT_CNT_EN
    .commit_count(commit_count),
`endif
    .dbg_state(dbg_state)
  );

  // scoreboard counters
  int n_pass = 0;
  int n_checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
  endtask

  // reference model: flags and a remaining-high-cycles count for the flush window
  logic [4:0]    m_wreg;
  logic [RW-1:0] m_wrob;
  logic [31:0]   m_wval, m_rpc, m_pops;
  logic          m_req, m_redir, m_clear, m_halted, m_waiting;
  int            m_flush_left;

  function automatic logic model_pop();
    if (rst || !rdy || m_halted) return 1'b0;
    if (m_waiting) return ack;
    if (m_flush_left > 0) return 1'b0;
    return hv && hr && (ht != T_STORE);
  endfunction

  task automatic model_edge();
    logic p;
    p = model_pop();
    if (rst) begin
      m_wreg = 0; m_wrob = 0; m_wval = 0; m_rpc = 0; m_pops = 0;
      m_req = 0; m_redir = 0; m_clear = 0; m_halted = 0; m_waiting = 0; m_flush_left = 0;
    end else if (rdy) begin
      if (p) m_pops = m_pops + 32'd1;
      m_wreg = 0;
      m_redir = 0;
      if (m_halted) begin
      end else if (m_waiting) begin
        if (ack) begin m_waiting = 0; m_req = 0; end
      end else if (m_flush_left > 0) begin
        m_flush_left--;
        m_clear = (m_flush_left > 0);
      end else if (hv && hr) begin
        if (ht == T_REG || ht == T_BRANCH) begin
          m_wreg = hrd; m_wrob = hrob; m_wval = hval;
          if (ht == T_BRANCH && hmis) begin
            m_redir = 1; m_rpc = htgt; m_clear = 1; m_flush_left = FC;
          end
        end else if (ht == T_STORE) begin
          m_req = 1; m_waiting = 1;
        end else begin
          m_halted = 1;
        end
      end
    end
  endtask

  task automatic chk_regs();
    chk("write_reg_id", 32'(write_reg_id), 32'(m_wreg));
    chk("write_ROB_id", 32'(write_ROB_id), 32'(m_wrob));
    chk("write_val", write_val, m_wval);
    chk("store_commit_req", 32'(store_commit_req), 32'(m_req));
    chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
    chk("redirect_pc", redirect_pc, m_rpc);
    chk("clear_flag", 32'(clear_flag), 32'(m_clear));
    chk("halted", 32'(halted), 32'(m_halted));
`ifdef COMMIT_CNT_EN
    chk("commit_count", commit_count, m_pops);
`endif
  endtask

  // driver: inputs are set after negedge; one call covers one clock cycle
  task automatic step();
    #1 chk("head_pop", 32'(head_pop), 32'(model_pop()));
    @(posedge clk);
    model_edge();
    #1 chk_regs();
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 0; rdy = 1; hv = 0; hr = 0; ht = 0; hrd = 0; hrob = 0;
    hval = 0; hmis = 0; htgt = 0; ack = 0;
  endtask

  task automatic set_head(input logic [1:0] t, input logic [4:0] rd, input logic [RW-1:0] rob,
                          input logic [31:0] v, input logic mis, input logic [31:0] tgt);
    hv = 1; hr = 1; ht = t; hrd = rd; hrob = rob; hval = v; hmis = mis; htgt = tgt;
  endtask

  typedef struct {
    logic          rdy, hv, hr;
    logic [1:0]    ht;
    logic [4:0]    rd;
    logic [RW-1:0] rob;
    logic [31:0]   val;
    logic          e_pop;
    logic [4:0]    e_wreg;
    logic [31:0]   e_wval;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, T_REG, 5'd5, 4'd3, 32'h1234, 1'b1, 5'd5, 32'h1234};
    tbl[1] = '{1'b1, 1'b0, 1'b0, T_REG, 5'd0, 4'd0, 32'h0,    1'b0, 5'd0, 32'h1234};
    tbl[2] = '{1'b1, 1'b1, 1'b1, T_REG, 5'd1, 4'd4, 32'h11,   1'b1, 5'd1, 32'h11};
    tbl[3] = '{1'b1, 1'b1, 1'b1, T_REG, 5'd2, 4'd5, 32'h22,   1'b1, 5'd2, 32'h22};
    tbl[4] = '{1'b1, 1'b1, 1'b1, T_REG, 5'd0, 4'd6, 32'h33,   1'b1, 5'd0, 32'h33};
    tbl[5] = '{1'b1, 1'b1, 1'b0, T_REG, 5'd9, 4'd7, 32'h44,   1'b0, 5'd0, 32'h33};
    tbl[6] = '{1'b0, 1'b1, 1'b1, T_REG, 5'd7, 4'd8, 32'h55,   1'b0, 5'd0, 32'h33};

    set_idle();
    rst = 1;
    @(negedge clk);
    step();
    step();
    rst = 0;
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_clear", 32'(clear_flag), 32'd0);

    for (int i = 0; i < 7; i++) begin
      set_idle();
      rdy = tbl[i].rdy; hv = tbl[i].hv; hr = tbl[i].hr; ht = tbl[i].ht;
      hrd = tbl[i].rd; hrob = tbl[i].rob; hval = tbl[i].val;
      #1 chk("tbl_pop", 32'(head_pop), 32'(tbl[i].e_pop));
      step();
      chk("tbl_wreg", 32'(write_reg_id), 32'(tbl[i].e_wreg));
      chk("tbl_wval", write_val, tbl[i].e_wval);
    end

    // store with a delayed ack
    set_idle();
    set_head(T_STORE, 5'd6, 4'd7, 32'hdead, 1'b0, 32'd0);
    step();
    chk("st_req", 32'(store_commit_req), 32'd1);
    chk("st_no_write", 32'(write_reg_id), 32'd0);
    repeat (3) step();
    chk("st_req_held", 32'(store_commit_req), 32'd1);
    ack = 1;
    #1 chk("st_pop_ack", 32'(head_pop), 32'd1);
    step();
    chk("st_req_drop", 32'(store_commit_req), 32'd0);
    chk("st_no_write2", 32'(write_reg_id), 32'd0);
    set_idle();
    step();

    // mispredicted branch followed by a waiting REG head
    set_head(T_BRANCH, 5'd1, 4'd8, 32'h104, 1'b1, 32'h200);
    step();
    chk("br_wreg", 32'(write_reg_id), 32'd1);
    chk("br_redir", 32'(redirect_valid), 32'd1);
    chk("br_rpc", redirect_pc, 32'h200);
    chk("br_clear1", 32'(clear_flag), 32'd1);
    set_head(T_REG, 5'd3, 4'd9, 32'h55, 1'b0, 32'd0);
    #1 chk("br_nopop1", 32'(head_pop), 32'd0);
    step();
    chk("br_clear2", 32'(clear_flag), 32'd1);
    chk("br_redir_pulse", 32'(redirect_valid), 32'd0);
    #1 chk("br_nopop2", 32'(head_pop), 32'd0);
    step();
    chk("br_clear_end", 32'(clear_flag), 32'd0);
    #1 chk("br_resume_pop", 32'(head_pop), 32'd1);
    step();
    chk("br_resume_wreg", 32'(write_reg_id), 32'd3);

    // rdy_in low inside the flush window
    set_head(T_BRANCH, 5'd2, 4'd10, 32'h108, 1'b1, 32'h300);
    step();
    set_idle();
    rdy = 0;
    repeat (3) step();
    chk("frz_clear", 32'(clear_flag), 32'd1);
    rdy = 1;
    step();
    chk("frz_clear2", 32'(clear_flag), 32'd1);
    step();
    chk("frz_clear_end", 32'(clear_flag), 32'd0);

    // halt is sticky until reset
    set_head(T_HALT, 5'd0, 4'd11, 32'd0, 1'b0, 32'd0);
    #1 chk("halt_pop", 32'(head_pop), 32'd1);
    step();
    chk("halt_set", 32'(halted), 32'd1);
    set_head(T_REG, 5'd4, 4'd12, 32'h77, 1'b0, 32'd0);
    #1 chk("halt_nopop", 32'(head_pop), 32'd0);
    repeat (3) step();
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_nowrite", 32'(write_reg_id), 32'd0);
    rst = 1;
    step();
    rst = 0;
    chk("halt_cleared", 32'(halted), 32'd0);

    // reset mid-store and mid-flush
    set_idle();
    set_head(T_STORE, 5'd0, 4'd1, 32'h1, 1'b0, 32'd0);
    step();
    rst = 1;
    step();
    chk("rst_store_req", 32'(store_commit_req), 32'd0);
    rst = 0;
    set_head(T_BRANCH, 5'd5, 4'd2, 32'h2, 1'b1, 32'h400);
    step();
    rst = 1;
    step();
    chk("rst_flush_clear", 32'(clear_flag), 32'd0);
    set_idle();
    step();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 99) < 3);
      rdy  = ($urandom_range(0, 99) < 90);
      hv   = ($urandom_range(0, 99) < 85);
      hr   = ($urandom_range(0, 99) < 80);
      begin
        int r;
        r = $urandom_range(0, 99);
        ht = (r < 50) ? T_REG : (r < 72) ? T_STORE : (r < 97) ? T_BRANCH : T_HALT;
      end
      hrd  = 5'($urandom_range(0, 31));
      hrob = RW'($urandom_range(0, (1 << RW) - 1));
      hval = $urandom;
      hmis = ($urandom_range(0, 99) < 40);
      htgt = $urandom;
      ack  = ($urandom_range(0, 99) < 35);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
